pc_fetch_sequencer: RTL and testbench

Owns the program counter of the pipelined CPU and sequences instruction fetch. It arbitrates between MEM-stage control-flow redirects, ID-stage load-use stalls and instruction-memory backpressure, and produces the fetch address, the IF/ID valid strobe and the pipeline flush signals. It replaces the ad-hoc PC write and stall glue around next-PC selection with a single stateful owner that keeps the fetch address stable across a multi-cycle instruction-memory access.

---
 rtl/pc_fetch_sequencer.sv | 158 +++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the CPU program counter and sequences instruction fetch.
// Arbitrates MEM-stage redirects, ID-stage load-use stalls and imem backpressure.
// Keeps the fetch address stable across multi-cycle instruction-memory accesses.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req / imem_addr      fetch request and address (address is pc_q)
//   imem_ready                instruction memory completes the current request
//   stall_id                  load-use stall from the hazard unit
//   mem_redirect / mem_target control-flow redirect resolved in MEM
//   pc_out / if_valid         PC and valid strobe for the IF/ID register
//   flush_if_id/_id_ex/_ex_mem  pipeline squash, combinational from mem_redirect
//   redirect_cnt / stall_cnt  saturating event counters
module pc_fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        stall_id,
   input  logic        mem_redirect,
   input  logic [31:0] mem_target,
   output logic [31:0] pc_out,
   output logic        if_valid,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic        flush_ex_mem,
   output logic [15:0] redirect_cnt,
   output logic [15:0] stall_cnt
);

   localparam int unsigned AW = 32;
   localparam int unsigned CW = 16;
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   typedef enum logic [1:0] {
      BOOT       = 2'd0,
      FETCH      = 2'd1,
      HOLD_REDIR = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] pend_q, pend_d;
   logic [CW-1:0] redirect_cnt_q, redirect_cnt_d;
   logic [CW-1:0] stall_cnt_q, stall_cnt_d;

   logic          req_c;
   logic          valid_c;
   logic          flush_c;
   logic          redir_inc_c;
   logic          stall_inc_c;
   logic [AW-1:0] target_aligned_c;

   assign target_aligned_c = {mem_target[AW-1:2], 2'b00};

   // Next-state and fetch control.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pend_d      = pend_q;
      req_c       = 1'b0;
      valid_c     = 1'b0;
      flush_c     = 1'b0;
      redir_inc_c = 1'b0;
      stall_inc_c = 1'b0;

      unique case (state_q)
         BOOT: begin
            state_d = FETCH;
         end

         FETCH: begin
            req_c = 1'b1;
            if (mem_redirect) begin
               flush_c     = 1'b1;
               redir_inc_c = 1'b1;
               if (imem_ready) begin
                  pc_d = target_aligned_c;
               end else begin
                  // Keep the in-flight address; apply the target once it returns.
                  pend_d  = target_aligned_c;
                  state_d = HOLD_REDIR;
               end
            end else if (stall_id) begin
               // Any completing fetch is dropped and the same PC is re-requested.
               stall_inc_c = 1'b1;
            end else if (imem_ready) begin
               valid_c = 1'b1;
               pc_d    = pc_q + AW'(4);
            end
         end

         HOLD_REDIR: begin
            // Wrong-path fetch in flight: never valid, stall_id ignored.
            req_c = 1'b1;
            if (mem_redirect) begin
               flush_c     = 1'b1;
               redir_inc_c = 1'b1;
               pend_d      = target_aligned_c;
               if (imem_ready) begin
                  pc_d    = target_aligned_c;
                  state_d = FETCH;
               end
            end else if (imem_ready) begin
               pc_d    = pend_q;
               state_d = FETCH;
            end
         end

         default: begin
            state_d = BOOT;
         end
      endcase

      redirect_cnt_d = redirect_cnt_q;
      if (redir_inc_c && (redirect_cnt_q != CNT_MAX)) begin
         redirect_cnt_d = redirect_cnt_q + CW'(1);
      end

      stall_cnt_d = stall_cnt_q;
      if (stall_inc_c && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CW'(1);
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= BOOT;
         pc_q           <= RESET_PC;
         pend_q         <= '0;
         redirect_cnt_q <= '0;
         stall_cnt_q    <= '0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         pend_q         <= pend_d;
         redirect_cnt_q <= redirect_cnt_d;
         stall_cnt_q    <= stall_cnt_d;
      end
   end

   // Strobes are masked while rst is high so nothing leaks out mid-reset.
   assign imem_req     = req_c   & ~rst;
   assign if_valid     = valid_c & ~rst;
   assign flush_if_id  = flush_c & ~rst;
   assign flush_id_ex  = flush_c & ~rst;
   assign flush_ex_mem = flush_c & ~rst;

   assign imem_addr    = pc_q;
   assign pc_out       = pc_q;
   assign redirect_cnt = redirect_cnt_q;
   assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed, table-driven bench for pc_fetch_sequencer (RESET_PC = 0x3000).
module tb_pc_fetch_sequencer;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        stall_id;
   logic        mem_redirect;
   logic [31:0] mem_target;
   logic [31:0] pc_out;
   logic        if_valid;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic        flush_ex_mem;
   logic [15:0] redirect_cnt;
   logic [15:0] stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   pc_fetch_sequencer #(.RESET_PC(32'h0000_3000)) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .stall_id     (stall_id),
      .mem_redirect (mem_redirect),
      .mem_target   (mem_target),
      .pc_out       (pc_out),
      .if_valid     (if_valid),
      .flush_if_id  (flush_if_id),
      .flush_id_ex  (flush_id_ex),
      .flush_ex_mem (flush_ex_mem),
      .redirect_cnt (redirect_cnt),
      .stall_cnt    (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        stall;
      logic        redir;
      logic [31:0] tgt;
      logic        req;
      logic [31:0] addr;
      logic        val;
      logic        fl;
      logic [15:0] rc;
      logic [15:0] sc;
   } vec_t;

   localparam int NV = 28;
   vec_t vecs [NV];

   function automatic vec_t mk(logic r, logic rdy, logic st, logic rd, logic [31:0] tgt,
                               logic req, logic [31:0] addr, logic val, logic fl,
                               logic [15:0] rc, logic [15:0] sc);
      vec_t v;
      v.rst = r; v.rdy = rdy; v.stall = st; v.redir = rd; v.tgt = tgt;
      v.req = req; v.addr = addr; v.val = val; v.fl = fl; v.rc = rc; v.sc = sc;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic rdy, input logic st, input logic rd,
                        input logic [31:0] tgt);
      rst = r; imem_ready = rdy; stall_id = st; mem_redirect = rd; mem_target = tgt;
   endtask

   task automatic check_vec(input int i, input vec_t v);
      chk("imem_req",     i, 32'(imem_req),     32'(v.req));
      chk("imem_addr",    i, imem_addr,         v.addr);
      chk("pc_out",       i, pc_out,            v.addr);
      chk("if_valid",     i, 32'(if_valid),     32'(v.val));
      chk("flush_if_id",  i, 32'(flush_if_id),  32'(v.fl));
      chk("flush_id_ex",  i, 32'(flush_id_ex),  32'(v.fl));
      chk("flush_ex_mem", i, 32'(flush_ex_mem), 32'(v.fl));
      chk("redirect_cnt", i, 32'(redirect_cnt), 32'(v.rc));
      chk("stall_cnt",    i, 32'(stall_cnt),    32'(v.sc));
   endtask

   initial begin
      //               rst rdy stl rdr target        req addr          val fl  rc  sc
      vecs[0]  = mk(1, 1, 0, 0, 32'h0,         0, 32'h0000_3000, 0, 0, 0, 0); // in reset
      vecs[1]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h0000_3000, 0, 0, 0, 0); // BOOT
      vecs[2]  = mk(0, 1, 0, 0, 32'h0,         1, 32'h0000_3000, 1, 0, 0, 0);
      vecs[3]  = mk(0, 1, 0, 0, 32'h0,         1, 32'h0000_3004, 1, 0, 0, 0);
      vecs[4]  = mk(0, 1, 1, 0, 32'h0,         1, 32'h0000_3008, 0, 0, 0, 0); // stall 1
      vecs[5]  = mk(0, 1, 1, 0, 32'h0,         1, 32'h0000_3008, 0, 0, 0, 1); // stall 2
      vecs[6]  = mk(0, 1, 0, 0, 32'h0,         1, 32'h0000_3008, 1, 0, 0, 2); // resume
      vecs[7]  = mk(0, 1, 0, 1, 32'h0000_4006, 1, 32'h0000_300C, 0, 1, 0, 2); // redirect
      vecs[8]  = mk(0, 1, 0, 1, 32'h0000_3010, 1, 32'h0000_4004, 0, 1, 1, 2); // aligned target
      vecs[9]  = mk(0, 0, 0, 1, 32'h0000_5000, 1, 32'h0000_3010, 0, 1, 2, 2); // -> HOLD
      vecs[10] = mk(0, 0, 0, 0, 32'h0,         1, 32'h0000_3010, 0, 0, 3, 2);
      vecs[11] = mk(0, 0, 0, 1, 32'h0000_6000, 1, 32'h0000_3010, 0, 1, 3, 2); // overwrite pend
      vecs[12] = mk(0, 1, 1, 0, 32'h0,         1, 32'h0000_3010, 0, 0, 4, 2); // stall ignored
      vecs[13] = mk(0, 1, 0, 0, 32'h0,         1, 32'h0000_6000, 1, 0, 4, 2);
      vecs[14] = mk(0, 1, 1, 1, 32'h0000_7000, 1, 32'h0000_6004, 0, 1, 4, 2); // redir beats stall
      vecs[15] = mk(0, 1, 0, 0, 32'h0,         1, 32'h0000_7000, 1, 0, 5, 2);
      vecs[16] = mk(0, 0, 0, 0, 32'h0,         1, 32'h0000_7004, 0, 0, 5, 2); // backpressure
      vecs[17] = mk(0, 1, 0, 0, 32'h0,         1, 32'h0000_7004, 1, 0, 5, 2);
      vecs[18] = mk(0, 0, 0, 1, 32'h0000_8000, 1, 32'h0000_7008, 0, 1, 5, 2); // -> HOLD
      vecs[19] = mk(0, 1, 0, 1, 32'h0000_9000, 1, 32'h0000_7008, 0, 1, 6, 2); // new wins w/ ready
      vecs[20] = mk(0, 1, 0, 0, 32'h0,         1, 32'h0000_9000, 1, 0, 7, 2);
      vecs[21] = mk(0, 1, 0, 1, 32'hFFFF_FFFE, 1, 32'h0000_9004, 0, 1, 7, 2);
      vecs[22] = mk(0, 1, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 0, 8, 2);
      vecs[23] = mk(0, 1, 0, 0, 32'h0,         1, 32'h0000_0000, 1, 0, 8, 2); // wrapped
      vecs[24] = mk(0, 0, 0, 1, 32'h0000_A000, 1, 32'h0000_0004, 0, 1, 8, 2); // -> HOLD
      vecs[25] = mk(1, 1, 0, 1, 32'h0000_B000, 0, 32'h0000_0004, 0, 0, 9, 2); // rst in HOLD
      vecs[26] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0000_3000, 0, 0, 0, 0); // BOOT
      vecs[27] = mk(0, 1, 0, 0, 32'h0,         1, 32'h0000_3000, 1, 0, 0, 0);

      drive(1, 1, 0, 0, 32'h0);
      repeat (2) @(posedge clk);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i].rst, vecs[i].rdy, vecs[i].stall, vecs[i].redir, vecs[i].tgt);
         #2;
         check_vec(i, vecs[i]);
      end

      // Redirect counter saturation: preload to all ones, redirect once more.
      @(negedge clk);
      drive(0, 1, 0, 0, 32'h0);
      force dut.redirect_cnt_q = 16'hFFFF;
      #1;
      release dut.redirect_cnt_q;
      #1;
      chk("rc_preload", 100, 32'(redirect_cnt), 32'h0000_FFFF);
      @(negedge clk);
      drive(0, 1, 0, 1, 32'h0000_0100);
      #2;
      chk("sat_flush", 101, 32'(flush_ex_mem), 32'h1);
      @(negedge clk);
      drive(0, 1, 0, 0, 32'h0);
      #2;
      chk("rc_saturated", 102, 32'(redirect_cnt), 32'h0000_FFFF);
      chk("sat_target",   103, imem_addr,          32'h0000_0100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
